// File: rtl/halftone_sequencer.sv
// Raster-order sequencer for a single-pixel error-diffusion halftone datapath; packs result bits into row words.
// Optional wait-for-datapath watchdog with sticky err output: define HALFTONE_SEQ_TIMEOUT_EN.
module halftone_sequencer #(
    parameter int N_ROWS = 6,
    parameter int N_COLS = 8,
    parameter int ADDR_W = 6
`ifdef HALFTONE_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [7:0]        pix_data,
    output logic              dp_valid,
    output logic [7:0]        dp_pixel,
    output logic              dp_first_row,
    output logic              dp_first_col,
    output logic              dp_last_col,
    input  logic              dp_done,
    input  logic              dp_bit,
    output logic [N_COLS-1:0] row_bits,
    output logic [2:0]        row_idx,
    output logic              row_valid,
    input  logic              row_ready
`ifdef HALFTONE_SEQ_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
    localparam logic [2:0]       ROW_LAST = 3'(N_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DP   = 3'd4,
        EMIT_ROW  = 3'd5,
        DONE_ST   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [N_COLS-1:0] row_bits_q, row_bits_d;
    logic [7:0]        dp_pixel_q, dp_pixel_d;
    logic [ADDR_W-1:0] addr_calc;

`ifdef HALFTONE_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            row_bits_q <= '0;
            dp_pixel_q <= '0;
`ifdef HALFTONE_SEQ_TIMEOUT_EN
            wait_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_bits_q <= row_bits_d;
            dp_pixel_q <= dp_pixel_d;
`ifdef HALFTONE_SEQ_TIMEOUT_EN
            wait_q     <= wait_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        row_bits_d = row_bits_q;
        dp_pixel_d = dp_pixel_q;
`ifdef HALFTONE_SEQ_TIMEOUT_EN
        wait_d     = wait_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d    = FETCH;
                    row_d      = '0;
                    col_d      = '0;
                    row_bits_d = '0;
`ifdef HALFTONE_SEQ_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end
            FETCH:     state_d = WAIT_DATA;
            WAIT_DATA: begin
                dp_pixel_d = pix_data;
                state_d    = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_DP;
`ifdef HALFTONE_SEQ_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            WAIT_DP: begin
                if (dp_done) begin
                    // Column 0 lands in the MSB of the row word.
                    for (int i = 0; i < N_COLS; i++) begin
                        if (col_q == COL_W'(N_COLS - 1 - i)) row_bits_d[i] = dp_bit;
                    end
                    if (col_q == COL_LAST) begin
                        state_d = EMIT_ROW;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = FETCH;
                    end
                end
`ifdef HALFTONE_SEQ_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            EMIT_ROW: begin
                if (row_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d = DONE_ST;
                    end else begin
                        row_d      = row_q + 1'b1;
                        col_d      = '0;
                        row_bits_d = '0;
                        state_d    = FETCH;
                    end
                end
            end
            DONE_ST:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign addr_calc    = ADDR_W'(row_q) * ADDR_W'(N_COLS) + ADDR_W'(col_q);

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE_ST);
    assign pix_rd       = (state_q == FETCH);
    assign pix_addr     = (state_q == FETCH) ? addr_calc : '0;
    assign dp_valid     = (state_q == ISSUE);
    assign dp_pixel     = dp_pixel_q;
    assign dp_first_row = (state_q == ISSUE) && (row_q == 3'd0);
    assign dp_first_col = (state_q == ISSUE) && (col_q == '0);
    assign dp_last_col  = (state_q == ISSUE) && (col_q == COL_LAST);
    assign row_bits     = row_bits_q;
    assign row_idx      = row_q;
    assign row_valid    = (state_q == EMIT_ROW);
`ifdef HALFTONE_SEQ_TIMEOUT_EN
    assign err          = err_q;
`endif

endmodule

// File: tb/tb_halftone_sequencer.sv
// Directed bench for halftone_sequencer: memory and datapath models plus a scoreboard of
// expected read addresses, pixel issues and row words.
module tb_halftone_sequencer;

    localparam int NR = 6;
    localparam int NC = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic          busy, done, pix_rd, dp_valid;
    logic [AW-1:0] pix_addr;
    logic [7:0]    pix_data = 8'd0;
    logic [7:0]    dp_pixel;
    logic          dp_first_row, dp_first_col, dp_last_col;
    logic          dp_done = 1'b0;
    logic          dp_bit = 1'b0;
    logic [NC-1:0] row_bits;
    logic [2:0]    row_idx;
    logic          row_valid;
    logic          row_ready = 1'b1;
`ifdef HALFTONE_SEQ_TIMEOUT_EN
    logic          err;
`endif

    halftone_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .busy         (busy),
        .done         (done),
        .pix_rd       (pix_rd),
        .pix_addr     (pix_addr),
        .pix_data     (pix_data),
        .dp_valid     (dp_valid),
        .dp_pixel     (dp_pixel),
        .dp_first_row (dp_first_row),
        .dp_first_col (dp_first_col),
        .dp_last_col  (dp_last_col),
        .dp_done      (dp_done),
        .dp_bit       (dp_bit),
        .row_bits     (row_bits),
        .row_idx      (row_idx),
        .row_valid    (row_valid),
        .row_ready    (row_ready)
`ifdef HALFTONE_SEQ_TIMEOUT_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    // Stimulus knobs, written only by the main initial block.
    int bit_mode = 0;
    bit const_pix = 1'b1;
    int drop_addr = -1;
    bit mon_en = 1'b1;
    int inj_req = 0;

    // Model state, written only by the model process.
    int mdl_addr = 0;
    int inj_done = 0;
    logic pend = 1'b0;
    logic pend_bit = 1'b0;

    // Monitor state, written only by the main initial block.
    logic          last_rv = 1'b0;
    logic [2:0]    last_idx = 3'd0;
    logic [NC-1:0] last_bits = '0;

    int         exp_addr_q[$];
    logic [10:0] exp_iss_q[$];
    logic [10:0] exp_row_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix_val(input int a);
        if (const_pix) return 8'd200;
        return 8'((a * 5 + 17) % 256);
    endfunction

    function automatic logic bit_of(input int a);
        case (bit_mode)
            0:       return 1'b1;
            1:       return ((a % NC) % 2) == 0;
            default: return (a % 3) == 0;
        endcase
    endfunction

    // Synchronous pixel memory and a datapath that answers in the first WAIT_DP cycle.
    always @(negedge clk) begin
        if (pix_rd) begin
            pix_data <= pix_val(int'(pix_addr));
            mdl_addr <= int'(pix_addr);
        end
        if (pix_rd && (inj_req != inj_done)) begin
            dp_done  <= 1'b1;
            dp_bit   <= ~bit_of(int'(pix_addr));
            inj_done <= inj_done + 1;
        end else begin
            dp_done <= pend;
            dp_bit  <= pend_bit;
        end
        pend     <= dp_valid && (mdl_addr != drop_addr);
        pend_bit <= bit_of(mdl_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (done) done_cnt++;
        if (mon_en) begin
            if (last_rv && row_ready) begin
                if (exp_row_q.size() == 0) chk("extra_row", 1, 0);
                else chk("row_word", {21'd0, last_idx, last_bits}, {21'd0, exp_row_q.pop_front()});
            end
            if (pix_rd) begin
                if (exp_addr_q.size() == 0) chk("extra_rd", 1, 0);
                else chk("pix_addr", 32'(pix_addr), exp_addr_q.pop_front());
            end
            if (dp_valid) begin
                if (exp_iss_q.size() == 0) chk("extra_issue", 1, 0);
                else chk("issue", {21'd0, dp_pixel, dp_first_row, dp_first_col, dp_last_col},
                         {21'd0, exp_iss_q.pop_front()});
            end
        end
        last_rv   = row_valid;
        last_idx  = row_idx;
        last_bits = row_bits;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
    endtask

    task automatic push_frame();
        logic [NC-1:0] bits;
        for (int r = 0; r < NR; r++) begin
            bits = '0;
            for (int c = 0; c < NC; c++) begin
                int a;
                a = r * NC + c;
                exp_addr_q.push_back(a);
                exp_iss_q.push_back({pix_val(a), r == 0, c == 0, c == NC - 1});
                bits[NC-1-c] = bit_of(a);
            end
            exp_row_q.push_back({3'(r), bits});
        end
    endtask

    task automatic clear_queues();
        exp_addr_q.delete();
        exp_iss_q.delete();
        exp_row_q.delete();
    endtask

    task automatic start_frame(output int g);
        push_frame();
        done_cnt = 0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        g = cyc;
        chk("busy_after_go", busy, 1);
`ifdef HALFTONE_SEQ_TIMEOUT_EN
        chk("err_clear_on_go", err, 0);
`endif
    endtask

    task automatic wait_done(input int g, input int dly, input bit poke);
        int i;
        i = 0;
        while (!done && i < 3000) begin
            if (poke) begin
                go = (i == 40) || (i == 90) || (i == 150);
                if (i == 20 || i == 120) inj_req++;
            end
            tick();
            i++;
        end
        go = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        else chk("done_delay", cyc - g, dly);
        tick();
        chk("done_one_cycle", {done, busy}, 0);
        chk("queues_empty", exp_addr_q.size() + exp_iss_q.size() + exp_row_q.size(), 0);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        int g;
        int i;
        logic [NC-1:0] cap;

        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_ctrl", {busy, done, pix_rd, dp_valid, row_valid, dp_first_row, dp_first_col, dp_last_col}, 0);
        chk("reset_data", {pix_addr, dp_pixel, row_bits, row_idx}, 0);
`ifdef HALFTONE_SEQ_TIMEOUT_EN
        chk("reset_err", err, 0);
`endif
        reset = 1'b0;
        tick();

        // All-ones image at constant 200.
        const_pix = 1'b1;
        bit_mode  = 0;
        start_frame(g);
        wait_done(g, 198, 1'b0);

        // Alternating bits, address-dependent pixels.
        const_pix = 1'b0;
        bit_mode  = 1;
        start_frame(g);
        wait_done(g, 198, 1'b0);

        // Row 2 held by downstream for 5 extra cycles.
        bit_mode = 2;
        start_frame(g);
        i = 0;
        while (!(pix_rd && pix_addr == AW'(23)) && i < 300) begin tick(); i++; end
        row_ready = 1'b0;
        i = 0;
        while (!row_valid && i < 20) begin tick(); i++; end
        chk("stall_reach_row2", {row_valid, row_idx}, {1'b1, 3'd2});
        cap = row_bits;
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk("stall_hold", {row_valid, pix_rd, row_idx, row_bits}, {1'b1, 1'b0, 3'd2, cap});
        end
        row_ready = 1'b1;
        tick();
        chk("stall_release", {row_valid, pix_rd}, {1'b0, 1'b1});
        wait_done(g, 203, 1'b0);

        // go pulses while busy and stray dp_done in FETCH.
        bit_mode = 1;
        start_frame(g);
        wait_done(g, 198, 1'b1);

        // Reset in WAIT_DP of row 3, column 4.
        bit_mode  = 2;
        drop_addr = 28;
        start_frame(g);
        i = 0;
        while (!(pix_rd && pix_addr == AW'(28)) && i < 300) begin tick(); i++; end
        tick();
        tick();
        chk("abort_issue", dp_valid, 1);
        tick();
        chk("abort_in_wait", {busy, dp_valid, pix_rd}, {1'b1, 1'b0, 1'b0});
        reset  = 1'b1;
        mon_en = 1'b0;
        tick();
        chk("abort_state", {busy, row_valid, done, pix_rd, dp_valid, row_idx, row_bits}, 0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("abort_no_done", done_cnt, 0);
        clear_queues();
        drop_addr = -1;
        last_rv   = 1'b0;
        mon_en    = 1'b1;
        start_frame(g);
        wait_done(g, 198, 1'b0);

`ifdef HALFTONE_SEQ_TIMEOUT_EN
        // Datapath never answers pixel 10.
        bit_mode  = 0;
        drop_addr = 10;
        start_frame(g);
        i = 0;
        while (!(pix_rd && pix_addr == AW'(10)) && i < 300) begin tick(); i++; end
        tick();
        tick();
        chk("to_issue", dp_valid, 1);
        repeat (15) tick();
        chk("to_before", {err, busy}, {1'b0, 1'b1});
        tick();
        chk("to_fire", {err, busy, row_valid}, {1'b1, 1'b0, 1'b0});
        repeat (5) tick();
        chk("to_idle", {err, busy, pix_rd}, {1'b1, 1'b0, 1'b0});
        chk("to_no_done", done_cnt, 0);
        clear_queues();
        drop_addr = -1;
        start_frame(g);
        wait_done(g, 198, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/halftone_sequencer.md
Name: halftone_sequencer

Overview:
Controller that sequences a single-pixel error-diffusion halftone datapath over an N_ROWS x N_COLS grey-scale image held in a synchronous pixel memory. Generates raster-order pixel read addresses and issues each pixel to the datapath with border flags. Collects the returned halftone bits into a row word and hands each completed row downstream over a valid/ready handshake. Sits between the frame memory and the halftone datapath; asserts done once the full image is converted.

Parameters:
N_ROWS, 6, image rows
N_COLS, 8, image columns (row word width)
ADDR_W, 6, pixel memory address width (must hold N_ROWS*N_COLS-1)
TIMEOUT, 15, max WAIT_DP cycles before error (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
go  in  1  start conversion; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of image
pix_rd  out  1  pixel memory read strobe
pix_addr  out  ADDR_W  read address = row*N_COLS + col
pix_data  in  8  read data, valid the cycle after pix_rd
dp_valid  out  1  one-cycle pixel issue to datapath
dp_pixel  out  8  pixel value, registered from pix_data
dp_first_row  out  1  row==0; datapath uses zero top-border error
dp_first_col  out  1  col==0; zero left-border error
dp_last_col  out  1  col==N_COLS-1; zero right-border error
dp_done  in  1  datapath result strobe; honoured only in WAIT_DP
dp_bit  in  1  halftone bit, valid with dp_done
row_bits  out  N_COLS  packed row; bit N_COLS-1 = column 0 (MSB first)
row_idx  out  3  row number of row_bits
row_valid  out  1  row word available
row_ready  in  1  downstream accepts row

Behaviour:
- Reset: all outputs 0, state IDLE, row=col=0, row_bits cleared. Reset mid-operation aborts immediately; no done and no partial row emitted.
- States: IDLE, FETCH, WAIT_DATA, ISSUE, WAIT_DP, EMIT_ROW, DONE_ST.
- IDLE: go=1 -> FETCH with row=0, col=0; go ignored in all other states.
- FETCH: pix_rd=1, pix_addr driven combinationally from row/col -> WAIT_DATA.
- WAIT_DATA: register pix_data into dp_pixel -> ISSUE.
- ISSUE: dp_valid=1 for exactly one cycle; dp_first_row/dp_first_col/dp_last_col valid in the same cycle -> WAIT_DP.
- WAIT_DP: stay until dp_done=1. On dp_done, write dp_bit into row_bits[N_COLS-1-col]. If col==N_COLS-1 -> EMIT_ROW, else col+1 -> FETCH.
- EMIT_ROW: row_valid=1; row_bits and row_idx held stable until row_ready=1. The row completes in the cycle where row_valid and row_ready are both 1. If row==N_ROWS-1 -> DONE_ST; else row+1, col=0, row_bits cleared -> FETCH.
- DONE_ST: done=1 for one cycle, busy=1 -> IDLE.
- Latency: 4 cycles/pixel minimum (dp_done in the first WAIT_DP cycle) plus 1 cycle/row minimum.
  - 6x8 with immediate dp_done and row_ready tied high: done high in the 199th cycle after the go-sampling edge (48*4 + 6 + 1).
- dp_done outside WAIT_DP is ignored. row_ready outside EMIT_ROW is ignored.
- Counters: col saturates logic at N_COLS-1, row at N_ROWS-1; no wrap past the image.

Optional Feature:
HALFTONE_SEQ_TIMEOUT_EN:
- Defined: adds output err (1 bit, sticky, cleared only by reset or by go in IDLE) and a wait counter.
  - Counter clears on entry to WAIT_DP and increments each WAIT_DP cycle without dp_done.
  - When the count reaches TIMEOUT: err=1, busy drops, state -> IDLE, no done pulse, row_valid stays 0.
- Undefined: no err port; WAIT_DP waits indefinitely.

Test Plan:
- Memory pixel value 200 everywhere; datapath model returns dp_bit=1 next cycle; row_ready=1 -> six rows, row_idx 0..5, each row_bits=8'hFF; done in the 199th cycle after go; pix_addr sequence 0..47.
- Alternating bits from datapath (1,0,1,0...) -> row_bits=8'hAA per row. Check dp_first_col only at cols 0, dp_last_col only at col 7, dp_first_row only on row 0.
- row_ready held low 5 cycles on row 2 -> row_valid and row_bits stable for 6 cycles; no pix_rd during stall; total done delay +5.
- Reset asserted in WAIT_DP of row 3, col 4 -> next cycle busy=0, row_valid=0, done never pulses; a new go restarts at pix_addr 0.
- go pulsed while busy, and dp_done pulsed in FETCH -> no effect; address sequence and bit capture unchanged.
- HALFTONE_SEQ_TIMEOUT_EN defined, datapath never answers pixel 10 -> err=1 after 15 WAIT_DP cycles, state IDLE, no done; go clears err and restarts.
